// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetch, stall hold registers, one-bubble redirect; FETCH_PERF_COUNT_EN adds fetch_count.
// Latency: mem[A] arrives the cycle after A is driven; backpressure: stall freezes the address and replays the held instruction.
module fetch_controller #(
  parameter logic [15:0] RESET_PC = 16'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [15:0] mem_address,
  input  logic [15:0] mem_instruction,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    RUN     = 2'd1,
    STALLED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc_q;
  logic [15:0] r_hold_instr;
  logic [15:0] r_hold_pc;
  logic [15:0] w_addr_nxt;
  logic [15:0] w_pc_nxt;
  logic [15:0] w_hold_instr_nxt;
  logic [15:0] w_hold_pc_nxt;
  logic [15:0] w_addr_inc;

  assign w_addr_inc = mem_address + 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= FILL;
      mem_address  <= RESET_PC;
      r_pc_q       <= RESET_PC;
      r_hold_instr <= 16'd0;
      r_hold_pc    <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      mem_address  <= w_addr_nxt;
      r_pc_q       <= w_pc_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = mem_address;
    w_pc_nxt         = r_pc_q;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    instr            = 16'd0;
    instr_pc         = 16'd0;
    instr_valid      = 1'b0;

    case (r_state)
      FILL: begin
        w_pc_nxt    = mem_address;
        w_addr_nxt  = w_addr_inc;
        w_state_nxt = RUN;
      end
      RUN: begin
        instr       = mem_instruction;
        instr_pc    = r_pc_q;
        instr_valid = 1'b1;
        if (stall) begin
          // Capture the returning word: the memory will move on, the consumer has not.
          w_hold_instr_nxt = mem_instruction;
          w_hold_pc_nxt    = r_pc_q;
          w_state_nxt      = STALLED;
        end else begin
          w_pc_nxt   = mem_address;
          w_addr_nxt = w_addr_inc;
        end
      end
      STALLED: begin
        instr       = r_hold_instr;
        instr_pc    = r_hold_pc;
        instr_valid = 1'b1;
        if (!stall) begin
          w_pc_nxt    = mem_address;
          w_addr_nxt  = w_addr_inc;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase

    // Redirect only affects next-state, so this cycle's outputs are untouched.
    if (redirect_valid) begin
      w_addr_nxt       = redirect_target;
      w_state_nxt      = FILL;
      w_hold_instr_nxt = 16'd0;
      w_hold_pc_nxt    = 16'd0;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_count <= 16'd0;
    end else if (instr_valid && !stall) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a one-cycle-latency instruction memory model.
// Checks reset, streaming, stall hold, redirect, redirect-over-stall, address wrap and reset mid-stall.
module tb_fetch_controller;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] mem_address;
  logic [15:0] mem_instruction;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] fetch_count;
`endif

  int checks;
  int passes;
  int exp_count;

  fetch_controller #(.RESET_PC(16'd5)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .mem_address     (mem_address),
    .mem_instruction (mem_instruction),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .fetch_count     (fetch_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  always @(posedge clock) mem_instruction <= mem_fn(mem_address);

  // Advance to the next negedge; exp_valid is the bench's own expectation for this cycle.
  task automatic adv(input logic exp_valid);
    if (exp_valid && !stall) exp_count = (exp_count + 1) & 16'hFFFF;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 16'h1234;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    exp_count = 0;
    checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else passes++;
    checks++; if (instr !== 16'h0000) $display("FAIL reset_instr: got %h expected 0000", instr); else passes++;
    checks++; if (instr_pc !== 16'h0000) $display("FAIL reset_pc: got %h expected 0000", instr_pc); else passes++;
    checks++; if (mem_address !== 16'h0005) $display("FAIL reset_addr: got %h expected 0005", mem_address); else passes++;
`ifdef FETCH_PERF_COUNT_EN
    checks++; if (fetch_count !== 16'h0000) $display("FAIL reset_count: got %h expected 0000", fetch_count); else passes++;
`endif
  endtask

  task automatic test_run();
    logic [15:0] ea [4];
    logic        ev [4];
    ea = '{16'd5, 16'd6, 16'd7, 16'd8};
    ev = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_address !== ea[i]) $display("FAIL run_addr[%0d]: got %h expected %h", i, mem_address, ea[i]); else passes++;
      checks++; if (instr_valid !== ev[i]) $display("FAIL run_valid[%0d]: got %b expected %b", i, instr_valid, ev[i]); else passes++;
      if (i > 0) begin
        checks++; if (instr_pc !== ea[i] - 16'd1) $display("FAIL run_pc[%0d]: got %h expected %h", i, instr_pc, ea[i] - 16'd1); else passes++;
        checks++; if (instr !== mem_fn(ea[i] - 16'd1)) $display("FAIL run_instr[%0d]: got %h expected %h", i, instr, mem_fn(ea[i] - 16'd1)); else passes++;
      end
      adv(ev[i]);
    end
  endtask

  task automatic test_stall();
    logic [15:0] epc;
    do_reset();
    adv(1'b0);
    adv(1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid); else passes++;
      checks++; if (instr_pc !== 16'd6) $display("FAIL stall_pc[%0d]: got %h expected 0006", i, instr_pc); else passes++;
      checks++; if (instr !== mem_fn(16'd6)) $display("FAIL stall_instr[%0d]: got %h expected %h", i, instr, mem_fn(16'd6)); else passes++;
      checks++; if (mem_address !== 16'd7) $display("FAIL stall_addr[%0d]: got %h expected 0007", i, mem_address); else passes++;
      adv(1'b1);
    end
    stall = 1'b0;
    checks++; if (instr_pc !== 16'd6) $display("FAIL stall_release_pc: got %h expected 0006", instr_pc); else passes++;
    checks++; if (instr !== mem_fn(16'd6)) $display("FAIL stall_release_instr: got %h expected %h", instr, mem_fn(16'd6)); else passes++;
    adv(1'b1);
    for (int i = 0; i < 2; i++) begin
      epc = 16'd7 + 16'(i);
      checks++; if (instr_pc !== epc) $display("FAIL post_stall_pc[%0d]: got %h expected %h", i, instr_pc, epc); else passes++;
      checks++; if (instr !== mem_fn(epc)) $display("FAIL post_stall_instr[%0d]: got %h expected %h", i, instr, mem_fn(epc)); else passes++;
      adv(1'b1);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_target = 16'd3;
    checks++; if (instr_pc !== 16'd9 || instr_valid !== 1'b1) $display("FAIL redir_same_cycle: got pc %h v %b expected pc 0009 v 1", instr_pc, instr_valid); else passes++;
    adv(1'b1);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) $display("FAIL redir_bubble: got %b expected 0", instr_valid); else passes++;
    checks++; if (mem_address !== 16'd3) $display("FAIL redir_addr: got %h expected 0003", mem_address); else passes++;
    adv(1'b0);
    checks++; if (instr_pc !== 16'd3 || instr_valid !== 1'b1) $display("FAIL redir_pc3: got pc %h v %b expected pc 0003 v 1", instr_pc, instr_valid); else passes++;
    redirect_valid = 1'b1;
    redirect_target = 16'h0040;
    adv(1'b1);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) $display("FAIL redir40_bubble: got %b expected 0", instr_valid); else passes++;
    adv(1'b0);
    checks++; if (instr_pc !== 16'h0040) $display("FAIL redir40_pc0: got %h expected 0040", instr_pc); else passes++;
    checks++; if (instr !== mem_fn(16'h0040)) $display("FAIL redir40_instr: got %h expected %h", instr, mem_fn(16'h0040)); else passes++;
    adv(1'b1);
    checks++; if (instr_pc !== 16'h0041) $display("FAIL redir40_pc1: got %h expected 0041", instr_pc); else passes++;
    adv(1'b1);
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    adv(1'b1);
    redirect_valid = 1'b1;
    redirect_target = 16'h0080;
    checks++; if (instr_pc !== 16'h0042 || instr_valid !== 1'b1) $display("FAIL rs_held: got pc %h v %b expected pc 0042 v 1", instr_pc, instr_valid); else passes++;
    adv(1'b1);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rs_fill: got %b expected 0", instr_valid); else passes++;
    checks++; if (mem_address !== 16'h0080) $display("FAIL rs_addr: got %h expected 0080", mem_address); else passes++;
    adv(1'b0);
    stall = 1'b0;
    checks++; if (instr_pc !== 16'h0080 || instr_valid !== 1'b1) $display("FAIL rs_target: got pc %h v %b expected pc 0080 v 1", instr_pc, instr_valid); else passes++;
    adv(1'b1);
  endtask

  task automatic test_wrap();
    logic [15:0] ep [3];
    ep = '{16'hFFFE, 16'hFFFF, 16'h0000};
    redirect_valid = 1'b1;
    redirect_target = 16'hFFFE;
    adv(1'b1);
    redirect_valid = 1'b0;
    adv(1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_pc !== ep[i]) $display("FAIL wrap_pc[%0d]: got %h expected %h", i, instr_pc, ep[i]); else passes++;
      checks++; if (mem_address !== ep[i] + 16'd1) $display("FAIL wrap_addr[%0d]: got %h expected %h", i, mem_address, ep[i] + 16'd1); else passes++;
      adv(1'b1);
    end
`ifdef FETCH_PERF_COUNT_EN
    checks++; if (fetch_count !== exp_count[15:0]) $display("FAIL fetch_count: got %0d expected %0d", fetch_count, exp_count); else passes++;
`endif
  endtask

  task automatic test_reset_stall();
    stall = 1'b1;
    adv(1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_count = 0;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rst_stall_valid: got %b expected 0", instr_valid); else passes++;
    checks++; if (mem_address !== 16'd5) $display("FAIL rst_stall_addr: got %h expected 0005", mem_address); else passes++;
`ifdef FETCH_PERF_COUNT_EN
    checks++; if (fetch_count !== 16'd0) $display("FAIL rst_stall_count: got %0d expected 0", fetch_count); else passes++;
`endif
    stall = 1'b0;
    adv(1'b0);
    checks++; if (instr_pc !== 16'd5 || instr_valid !== 1'b1) $display("FAIL rst_stall_resume: got pc %h v %b expected pc 0005 v 1", instr_pc, instr_valid); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    exp_count = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 16'h0000;
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have one parameter, RESET_PC, default 16'd0, giving the first fetch address after reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  consumer did not accept instr this cycle.
REQ-006 redirect_valid  input  1  branch/jump request this cycle.
REQ-007 redirect_target  input  16  new fetch address.
REQ-008 mem_address  output  16  registered address to instruction memory AddressBus.
REQ-009 mem_instruction  input  16  instruction memory data; mem[A] is valid in the cycle after A is presented on mem_address.
REQ-010 instr  output  16  fetched instruction.
REQ-011 instr_pc  output  16  address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc are valid.

Function
REQ-013 The FSM SHALL have three states: FILL (no in-flight fetch), RUN (in-flight fetch, outputs pass through from memory) and STALLED (outputs from hold registers).
REQ-014 Registers SHALL be mem_address, pc_q (address presented last cycle), hold_instr, hold_pc and state.
REQ-015 In FILL, instr_valid SHALL be 0; at the clock edge the block SHALL set pc_q<=mem_address, mem_address<=mem_address+1 and state<=RUN.
REQ-016 In RUN, outputs SHALL be instr=mem_instruction, instr_pc=pc_q and instr_valid=1, all combinational.
REQ-017 In RUN with stall=0, at the edge: pc_q<=mem_address, mem_address<=mem_address+1.
REQ-018 In RUN with stall=1, at the edge: hold_instr<=mem_instruction, hold_pc<=pc_q, state<=STALLED; mem_address and pc_q SHALL hold.
REQ-019 In STALLED, outputs SHALL be instr=hold_instr, instr_pc=hold_pc and instr_valid=1; mem_address and pc_q SHALL hold.
REQ-020 STALLED with stall=1 SHALL remain in STALLED.
REQ-021 STALLED with stall=0 SHALL, at the edge: pc_q<=mem_address, mem_address<=mem_address+1, state<=RUN.
REQ-022 Across any stall, no instruction SHALL be lost or duplicated.
REQ-023 redirect_valid=1 in any state SHALL take priority over stall: at the edge mem_address<=redirect_target and state<=FILL, discarding the in-flight fetch and any hold contents.
REQ-024 During a redirect, outputs in the redirect cycle itself SHALL be unaffected.
REQ-025 The redirect penalty SHALL be exactly one bubble: instr_valid=0 in the cycle after a redirect, and mem[target] is presented the following cycle.
REQ-026 In FILL, stall SHALL be ignored.
REQ-027 Address increment SHALL be modulo 2^16: 16'hFFFF+1 = 16'h0000, with no flag.
REQ-028 Steady-state throughput SHALL be one instruction per cycle when stall=0.

Reset
REQ-029 When reset=1 at a rising edge, the block SHALL set mem_address<=RESET_PC, pc_q<=RESET_PC, hold_instr<=0, hold_pc<=0 and state<=FILL, overriding redirect_valid and stall.
REQ-030 In the cycle after reset, instr_valid SHALL be 0, instr SHALL be 0 and instr_pc SHALL be 0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard all pending state.

Configuration
REQ-032 The macro FETCH_PERF_COUNT_EN SHALL control an accepted-instruction counter.
REQ-033 When FETCH_PERF_COUNT_EN is defined, the block SHALL add output fetch_count (16 bits), reset to 0, incremented by 1 on each edge where instr_valid=1 and stall=0, and wrapping from 16'hFFFF to 0.
REQ-034 When FETCH_PERF_COUNT_EN is undefined, the fetch_count port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-035 Reset with RESET_PC=5, then run 4 cycles with stall=0 -> mem_address sequence 5,6,7,8; instr_valid 0,1,1,1; instr_pc 5,6,7 from the second cycle.
REQ-036 Stall for 3 cycles while instr_pc=6 -> instr_pc=6 and instr=mem[6] held all 3 cycles; after release, instr_pc sequence 7,8 with no gap or repeat.
REQ-037 Redirect to 16'h0040 while instr_pc=3 -> next cycle instr_valid=0; following cycle instr_pc=16'h0040, then 16'h0041.
REQ-038 Redirect and stall asserted together in STALLED -> redirect wins: FILL state, then instr_pc=target.
REQ-039 Redirect to 16'hFFFE -> instr_pc sequence FFFE, FFFF, 0000.
REQ-040 Assert reset during STALLED -> next cycle instr_valid=0 and mem_address=RESET_PC; with FETCH_PERF_COUNT_EN defined, fetch_count=0 after reset and equals the number of accepted instructions across the above scenarios.
